// File: rtl/decoder_pkg.sv
// Shared types and helpers for the hold-window one-hot decoder.
package decoder_pkg;

    localparam int CNT_W      = 8;
    localparam int MAX_CODE_W = 8;
    localparam int MAX_OUT_W  = 2 ** MAX_CODE_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Widest one-hot word; callers slice down to their own output width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
        logic [MAX_OUT_W-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot converter, shared by the direct and buffered load paths.
module onehot_dec
    import decoder_pkg::*;
#(
    parameter int CODE_W = 2
) (
    input  logic [CODE_W-1:0]      code,
    output logic [2**CODE_W-1:0]   oh
);

    logic [MAX_OUT_W-1:0] oh_full;
    logic                 unused_bits;

    assign oh_full     = onehot(MAX_CODE_W'(code));
    assign oh          = oh_full[2**CODE_W-1:0];
    assign unused_bits = ^oh_full;

endmodule

// File: rtl/decoder_hold.sv
// Registered one-hot decoder: each accepted code is held for HOLD enabled cycles,
// with a one-entry buffer so back-to-back codes show with no gap.
module decoder_hold
    import decoder_pkg::*;
#(
    parameter int CODE_W = 2,
    parameter int HOLD   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CODE_W-1:0]    code,
    input  logic                 en,
    output logic [2**CODE_W-1:0] out,
    output logic                 out_valid,
    output logic [CNT_W-1:0]     dec_cnt
);

    localparam int OUT_W = 2 ** CODE_W;
    localparam logic [7:0] HCNT_RELOAD = 8'(HOLD - 1);

    state_t              state_q, state_d;
    logic [OUT_W-1:0]    oh_q, oh_d;
    logic [7:0]          hcnt_q, hcnt_d;
    logic [CODE_W-1:0]   buf_code_q, buf_code_d;
    logic                buf_full_q, buf_full_d;
    logic [CNT_W-1:0]    dec_cnt_q, dec_cnt_d;

    logic                accept;
    logic [CODE_W-1:0]   load_code;
    logic [OUT_W-1:0]    load_oh;

    assign in_ready = rst_n && !buf_full_q;
    assign accept   = in_valid && in_ready;

    // A full buffer always wins over a new code, and blocks new accepts anyway.
    assign load_code = buf_full_q ? buf_code_q : code;

    onehot_dec #(
        .CODE_W (CODE_W)
    ) u_onehot_dec (
        .code (load_code),
        .oh   (load_oh)
    );

    always_comb begin
        state_d    = state_q;
        oh_d       = oh_q;
        hcnt_d     = hcnt_q;
        buf_code_d = buf_code_q;
        buf_full_d = buf_full_q;
        dec_cnt_d  = dec_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    oh_d    = load_oh;
                    hcnt_d  = HCNT_RELOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (en && hcnt_q == 8'd0) begin
                    dec_cnt_d = dec_cnt_q + CNT_W'(1);
                    if (buf_full_q || accept) begin
                        oh_d       = load_oh;
                        hcnt_d     = HCNT_RELOAD;
                        buf_full_d = 1'b0;
                    end else begin
                        oh_d    = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (en) begin
                        hcnt_d = hcnt_q - 8'd1;
                    end
                    if (accept) begin
                        buf_code_d = code;
                        buf_full_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            oh_q       <= '0;
            hcnt_q     <= '0;
            buf_code_q <= '0;
            buf_full_q <= 1'b0;
            dec_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            oh_q       <= oh_d;
            hcnt_q     <= hcnt_d;
            buf_code_q <= buf_code_d;
            buf_full_q <= buf_full_d;
            dec_cnt_q  <= dec_cnt_d;
        end
    end

    assign out       = (rst_n && en) ? oh_q : '0;
    assign out_valid = rst_n && (state_q == ST_HOLD);
    assign dec_cnt   = dec_cnt_q;

endmodule

// File: tb/tb_decoder_hold.sv
// Two decoders (HOLD=4 and HOLD=1) driven with shared stimulus and checked against a window model.
module tb_decoder_hold;

    localparam int CODE_W = 2;
    localparam int OUT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, en;
    logic [CODE_W-1:0] code;

    logic              rdy_a, ov_a, rdy_b, ov_b;
    logic [OUT_W-1:0]  out_a, out_b;
    logic [7:0]        cnt_a, cnt_b;

    always #5 clk = ~clk;

    decoder_hold #(.CODE_W(CODE_W), .HOLD(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .code(code), .en(en), .out(out_a), .out_valid(ov_a), .dec_cnt(cnt_a)
    );

    decoder_hold #(.CODE_W(CODE_W), .HOLD(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .code(code), .en(en), .out(out_b), .out_valid(ov_b), .dec_cnt(cnt_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a window shows `cur` for `rem` more enabled cycles; one pending code may wait.
    int hold_len[2] = '{4, 1};
    bit m_act[2];
    int m_cur[2];
    int m_rem[2];
    bit m_bf[2];
    int m_bc[2];
    int m_cnt[2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_cur[i] = 0; m_rem[i] = 0;
            m_bf[i] = 0;  m_bc[i] = 0;  m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input int c, input bit e);
        bit acc;
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                m_act[i] = 0; m_rem[i] = 0; m_bf[i] = 0; m_cnt[i] = 0;
                continue;
            end
            acc = v && !m_bf[i];
            if (acc) $display("accept inst=%0d code=%0d t=%0t", i, c, $time);
            if (!m_act[i]) begin
                if (acc) begin
                    m_act[i] = 1; m_cur[i] = c; m_rem[i] = hold_len[i];
                end
            end else if (e) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_cnt[i] = (m_cnt[i] + 1) % 256;
                    if (m_bf[i]) begin
                        m_cur[i] = m_bc[i]; m_bf[i] = 0; m_rem[i] = hold_len[i];
                    end else if (acc) begin
                        m_cur[i] = c; m_rem[i] = hold_len[i];
                    end else begin
                        m_act[i] = 0;
                    end
                end else if (acc) begin
                    m_bf[i] = 1; m_bc[i] = c;
                end
            end else if (acc) begin
                m_bf[i] = 1; m_bc[i] = c;
            end
        end
    endtask

    // One cycle: drive, compare all outputs of both instances, then advance the model at the edge.
    task automatic step(input bit r, input bit v, input int c, input bit e);
        logic [31:0] exp_out;
        @(negedge clk);
        rst_n = r; in_valid = v; code = CODE_W'(c); en = e;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_out = (r && e && m_act[i]) ? (32'd1 << m_cur[i]) : 32'd0;
            check($sformatf("out%0d", i),  32'(i == 0 ? out_a : out_b), exp_out);
            check($sformatf("ov%0d", i),   32'(i == 0 ? ov_a : ov_b),   32'(r && m_act[i]));
            check($sformatf("rdy%0d", i),  32'(i == 0 ? rdy_a : rdy_b), 32'(r && !m_bf[i]));
            check($sformatf("cnt%0d", i),  32'(i == 0 ? cnt_a : cnt_b), 32'(m_cnt[i]));
        end
        @(posedge clk);
        model_edge(r, v, c, e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 1);
    endtask

    initial begin
        int nxt;
        bit acc0;
        rst_n = 0; in_valid = 0; code = '0; en = 1;
        model_clear();
        @(posedge clk);
        step(0, 0, 0, 1);
        step(0, 1, 3, 1);

        // Single code 2 held for four cycles
        step(1, 1, 2, 1);
        idle(6);
        #1;
        check("t1_cnt", 32'(cnt_a), 32'd1);
        check("t1_ov",  32'(ov_a),  32'd0);

        // Streamed codes 0..3 with in_valid held
        step(0, 0, 0, 1);
        nxt = 0;
        for (int k = 0; k < 24; k++) begin
            acc0 = (nxt < 4) && !m_bf[0];
            step(1, nxt < 4, nxt, 1);
            if (acc0) nxt++;
        end
        idle(4);
        #1;
        check("stream_cnt", 32'(cnt_a), 32'd4);

        // Consecutive codes 3,0,1
        step(0, 0, 0, 1);
        step(1, 1, 3, 1);
        step(1, 1, 0, 1);
        step(1, 1, 1, 1);
        idle(2);
        #1;
        check("h1_cnt", 32'(cnt_b), 32'd3);
        idle(12);

        // en gap of three cycles mid-window
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        step(1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0);
        idle(5);
        #1;
        check("gap_cnt", 32'(cnt_a), 32'd1);

        // Reset with a buffered code pending
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        step(1, 1, 2, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        idle(6);
        #1;
        check("rst_cnt", 32'(cnt_a), 32'd0);

        // Random traffic
        for (int k = 0; k < 800; k++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0);
        end

        // Counter wrap: 299 single-cycle windows on the HOLD=1 instance
        step(0, 0, 0, 1);
        for (int k = 0; k < 300; k++) step(1, 1, int'($urandom_range(0, 3)), 1);
        #1;
        check("wrap_cnt", 32'(cnt_b), 32'd43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
